// File: rtl/store_narrow_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : store_pkg
// Brief    : Shared encodings for the store-narrowing unit (size codes, FSM
//            states) and the alignment check used when a request is accepted.
// Revision : 1.0 - initial release
// ============================================================================
package store_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WAIT = 3'd2,
    S_WR   = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_e;

  // True when the request can never be served: reserved size, or a half/word
  // that does not sit on its natural boundary.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = offset[0];
      SZ_WORD: bad = (offset != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_narrow_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : store_narrow_unit_if
// Brief    : Request/response bus between MEM-stage control and the store
//            unit, plus the word-organised data RAM port.
// Revision : 1.0 - initial release
// ============================================================================
interface store_narrow_unit_if #(
  parameter int MEM_AW = 10
);
  logic              start;
  logic [1:0]        size;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              misalign;
  logic [MEM_AW-1:0] mem_addr;
  logic              mem_rd_en;
  logic [31:0]       mem_rdata;
  logic              mem_we;
  logic [31:0]       mem_wdata;

  // Controller plus RAM side: issues requests, returns read data.
  modport master (
    output start, size, addr, wdata, mem_rdata,
    input  busy, done, misalign, mem_addr, mem_rd_en, mem_we, mem_wdata
  );

  // Store unit side.
  modport slave (
    input  start, size, addr, wdata, mem_rdata,
    output busy, done, misalign, mem_addr, mem_rd_en, mem_we, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/store_narrow_unit_lane_merge.sv
`default_nettype none
// ============================================================================
// Module   : lane_merge
// Brief    : Little-endian byte/half lane insertion into an existing word.
//            Word size passes the data straight through.
// Revision : 1.0 - initial release
// ============================================================================
module lane_merge
  import store_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  output logic [31:0] new_word
);

  // Overwrite only the addressed lane; every other bit keeps the old word.
  always_comb begin
    new_word = old_word;
    case (size)
      SZ_BYTE: new_word[{offset, 3'b000} +: 8]        = data[7:0];
      SZ_HALF: new_word[{offset[1], 4'b0000} +: 16]   = data[15:0];
      SZ_WORD: new_word                               = data;
      default: new_word                               = old_word;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_narrow_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_narrow_unit
// Brief    : Narrows a register value to byte/half/word and stores it into
//            word-organised synchronous RAM. Sub-word stores read-modify-
//            write; word stores write directly; bad alignment reports an
//            error without touching memory.
// Revision : 1.0 - initial release
// ============================================================================
module store_narrow_unit
  import store_pkg::*;
#(
  parameter int MEM_AW = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  store_narrow_unit_if.slave  bus
);

  state_e      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [1:0]  size_q,  size_d;
  logic [31:0] data_q,  data_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] merged;

  lane_merge u_lane_merge (
    .old_word (bus.mem_rdata),
    .data     (data_q),
    .size     (size_q),
    .offset   (addr_q[1:0]),
    .new_word (merged)
  );

  // State and request latches; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      data_q  <= '0;
      merge_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      data_q  <= data_d;
      merge_q <= merge_d;
    end
  end

  // Next-state and Moore outputs; memory address only driven while the
  // RAM is being used so the bus idles at zero.
  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    size_d        = size_q;
    data_d        = data_q;
    merge_d       = merge_q;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    bus.misalign  = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_rd_en = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    case (state_q)
      S_IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) begin
          addr_d = bus.addr;
          size_d = bus.size;
          data_d = bus.wdata;
          if (is_misaligned(bus.size, bus.addr[1:0])) begin
            state_d = S_ERR;
          end else if (bus.size == SZ_WORD) begin
            state_d = S_WR;
          end else begin
            state_d = S_RD;
          end
        end
      end
      S_RD: begin
        bus.mem_addr  = addr_q[MEM_AW+1:2];
        bus.mem_rd_en = 1'b1;
        state_d       = S_WAIT;
      end
      S_WAIT: begin
        bus.mem_addr = addr_q[MEM_AW+1:2];
        merge_d      = merged;
        state_d      = S_WR;
      end
      S_WR: begin
        bus.mem_addr  = addr_q[MEM_AW+1:2];
        bus.mem_we    = 1'b1;
        bus.mem_wdata = (size_q == SZ_WORD) ? data_q : merge_q;
        state_d       = S_DONE;
      end
      S_DONE: begin
        bus.done = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        bus.done     = 1'b1;
        bus.misalign = 1'b1;
        state_d      = S_IDLE;
      end
      default: begin
        bus.busy = 1'b0;
        state_d  = S_IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_store_narrow_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_narrow_unit
// Brief    : Directed bench for store_narrow_unit with a synchronous RAM
//            model and hand-computed expected words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_narrow_unit;

  localparam int MEM_AW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   both_cnt = 0;
  int   done_cnt = 0;
  logic [MEM_AW-1:0] wr_addr = '0;
  logic [31:0]       wr_data = '0;
  int   wr_cyc [64];
  logic [31:0] tb_mem [2**MEM_AW];

  store_narrow_unit_if #(.MEM_AW(MEM_AW)) bus ();

  store_narrow_unit #(.MEM_AW(MEM_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous RAM: read data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_rdata <= tb_mem[bus.mem_addr];
    if (bus.mem_we)    tb_mem[bus.mem_addr] <= bus.mem_wdata;
  end

  // Access monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_we) begin
      wr_cyc[wr_cnt % 64] = cyc;
      wr_cnt  = wr_cnt + 1;
      wr_addr = bus.mem_addr;
      wr_data = bus.mem_wdata;
    end
    if (bus.mem_rd_en) rd_cnt = rd_cnt + 1;
    if (bus.mem_rd_en && bus.mem_we) both_cnt = both_cnt + 1;
    if (bus.done) done_cnt = done_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    total = total + 1;
    if (obs !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request and check latency, error flag and memory traffic.
  task automatic run_op(input string tag, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int exp_lat, input logic exp_mis,
                        input int exp_rd, input int exp_wr,
                        input logic [31:0] exp_waddr,
                        input logic [31:0] exp_wdata);
    int rd0, wr0, both0, n;
    logic got;
    @(negedge clk);
    bus.start = 1'b1;
    bus.size  = sz;
    bus.addr  = a;
    bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    rd0 = rd_cnt; wr0 = wr_cnt; both0 = both_cnt;
    n = 0; got = 1'b0;
    while (!got && n < 12) begin
      @(negedge clk);
      n = n + 1;
      if (bus.done) got = 1'b1;
    end
    check_eq({tag, "_lat"}, n, exp_lat);
    check_eq({tag, "_mis"}, {31'd0, bus.misalign}, {31'd0, exp_mis});
    #1;
    check_eq({tag, "_rd"}, rd_cnt - rd0, exp_rd);
    check_eq({tag, "_wr"}, wr_cnt - wr0, exp_wr);
    check_eq({tag, "_both"}, both_cnt - both0, 0);
    if (exp_wr != 0) begin
      check_eq({tag, "_waddr"}, {22'd0, wr_addr}, exp_waddr);
      check_eq({tag, "_wdata"}, wr_data, exp_wdata);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_busy"},  {31'd0, bus.busy}, 0);
    check_eq({tag, "_done"},  {31'd0, bus.done}, 0);
    check_eq({tag, "_mis"},   {31'd0, bus.misalign}, 0);
    check_eq({tag, "_rden"},  {31'd0, bus.mem_rd_en}, 0);
    check_eq({tag, "_we"},    {31'd0, bus.mem_we}, 0);
    check_eq({tag, "_maddr"}, {22'd0, bus.mem_addr}, 0);
    check_eq({tag, "_mwd"},   bus.mem_wdata, 0);
  endtask

  initial begin
    int base, wr0, rd0, dn0;
    bus.start = 1'b0; bus.size = 2'b00; bus.addr = '0; bus.wdata = '0;
    bus.mem_rdata = '0;
    repeat (3) @(negedge clk);
    check_idle_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // Preload and the plain word store.
    run_op("pre1", 2'b10, 32'h4,  32'h11223344, 2, 0, 0, 1, 1, 32'h11223344);
    run_op("pre0", 2'b10, 32'h0,  32'hAAAABBBB, 2, 0, 0, 1, 0, 32'hAAAABBBB);
    run_op("word", 2'b10, 32'h8,  32'hDEADBEEF, 2, 0, 0, 1, 2, 32'hDEADBEEF);
    // Sub-word read-modify-write across lanes.
    run_op("byte2", 2'b00, 32'h6, 32'hFFFFFFAB, 4, 0, 1, 1, 1, 32'h11AB3344);
    run_op("half1", 2'b01, 32'h2, 32'h00001234, 4, 0, 1, 1, 0, 32'h1234BBBB);
    run_op("byte3", 2'b00, 32'h7, 32'h000000CD, 4, 0, 1, 1, 1, 32'hCDAB3344);
    run_op("half0", 2'b01, 32'h0, 32'hFFFF5678, 4, 0, 1, 1, 0, 32'h12345678);
    run_op("byte0", 2'b00, 32'h8, 32'h00000001, 4, 0, 1, 1, 2, 32'hDEADBE01);
    check_eq("mem1", tb_mem[1], 32'hCDAB3344);
    check_eq("mem0", tb_mem[0], 32'h12345678);
    check_eq("mem2", tb_mem[2], 32'hDEADBE01);
    // Upper address bits wrap onto the same word.
    run_op("wrap", 2'b10, 32'h1008, 32'hCAFEF00D, 2, 0, 0, 1, 2, 32'hCAFEF00D);
    check_eq("mem2w", tb_mem[2], 32'hCAFEF00D);
    // Error cases: no memory traffic, one-cycle done+misalign.
    run_op("errh", 2'b01, 32'h3, 32'h0,  1, 1, 0, 0, 0, 0);
    run_op("errw", 2'b10, 32'h2, 32'h0,  1, 1, 0, 0, 0, 0);
    run_op("errr", 2'b11, 32'h0, 32'h0,  1, 1, 0, 0, 0, 0);
    check_eq("mem0e", tb_mem[0], 32'h12345678);

    // Reset during WAIT aborts with no write.
    run_op("pre4", 2'b10, 32'h10, 32'h55667788, 2, 0, 0, 1, 4, 32'h55667788);
    @(negedge clk);
    bus.start = 1'b1; bus.size = 2'b00; bus.addr = 32'h11; bus.wdata = 32'h99;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wr0 = wr_cnt;
    @(negedge clk);
    check_eq("rmo_rd", {31'd0, bus.mem_rd_en}, 1);
    @(negedge clk);
    check_eq("rmo_wait", {31'd0, bus.busy}, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_idle_outputs("rmo");
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rmo_we", {31'd0, bus.mem_we}, 0);
    repeat (2) @(negedge clk);
    #1;
    check_eq("rmo_wr", wr_cnt - wr0, 0);
    check_eq("rmo_mem", tb_mem[4], 32'h55667788);

    // Start held high: one word store every three cycles.
    @(negedge clk);
    bus.start = 1'b1; bus.size = 2'b10; bus.addr = 32'h20; bus.wdata = 32'h0BADF00D;
    @(posedge clk);
    #1;
    base = cyc; wr0 = wr_cnt; rd0 = rd_cnt; dn0 = done_cnt;
    repeat (9) @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check_eq("b2b_wr",   wr_cnt - wr0, 3);
    check_eq("b2b_rd",   rd_cnt - rd0, 0);
    check_eq("b2b_done", done_cnt - dn0, 3);
    check_eq("b2b_t0", wr_cyc[wr0 % 64] - base, 0);
    check_eq("b2b_t1", wr_cyc[(wr0 + 1) % 64] - wr_cyc[wr0 % 64], 3);
    check_eq("b2b_t2", wr_cyc[(wr0 + 2) % 64] - wr_cyc[(wr0 + 1) % 64], 3);
    check_eq("b2b_mem", tb_mem[8], 32'h0BADF00D);
    check_eq("b2b_idle", {31'd0, bus.busy}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-side counterpart of the load path's 16→32 sign extension: narrows a 32-bit register value to byte, halfword or word and writes it into word-organised data memory.
- Byte and halfword stores use a read-modify-write sequence; word stores write directly.
- Sits between the multi-cycle CPU's MEM stage control and the data RAM.
- The controller holds in the MEM state until `done`.

Parameters:
- MEM_AW, 10, word-address width of data memory (depth 2^MEM_AW words)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- size  in  2  00 byte, 01 half, 10 word, 11 reserved (error)
- addr  in  32  byte address
- wdata  in  32  register value; low byte/half used when narrowing
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle completion pulse
- misalign  out  1  one-cycle error pulse, coincident with done
- mem_addr  out  MEM_AW  word address = addr_q[MEM_AW+1:2]
- mem_rd_en  out  1  memory read strobe
- mem_rdata  in  32  read data, valid the cycle after mem_rd_en (synchronous RAM)
- mem_we  out  1  memory write strobe
- mem_wdata  out  32  merged write word

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - state→IDLE.
  - busy, done, misalign, mem_rd_en and mem_we are 0.
  - mem_addr, mem_wdata and the internal latches (addr_q, size_q, data_q, merge_q) are 0.
- Reset mid-operation aborts with no write; mem_we is 0 in the cycle after reset is released.
- IDLE with start=1:
  - Latch addr, size and wdata.
  - Next state:
    - ERR if size=11, or size=01 with addr[0]=1, or size=10 with addr[1:0]≠00.
    - WR if word.
    - RD otherwise.
- start outside IDLE is ignored. No queueing.
- States and outputs:
  - RD: mem_rd_en=1 → WAIT.
  - WAIT: merge_q ← merge(mem_rdata) → WR.
  - WR: mem_we=1; mem_wdata = merge_q (byte/half) or data_q (word) → DONE.
  - DONE: done=1 → IDLE.
  - ERR: done=1, misalign=1; no memory access → IDLE.
- Latency from the start-sampling edge to the done-high cycle:
  - word: 2 cycles (WR, DONE)
  - byte/half: 4 cycles (RD, WAIT, WR, DONE)
  - error: 1 cycle
- Merge is little-endian:
  - byte lane k=addr_q[1:0] replaces bits [8k+7:8k] with data_q[7:0].
  - half lane h=addr_q[1] replaces bits [16h+15:16h] with data_q[15:0].
  - Other bits keep mem_rdata. Upper bits of data_q are discarded; no sign handling.
- mem_addr is driven from addr_q in RD, WAIT and WR; it is 0 otherwise. Address bits above MEM_AW+1 are ignored (wrap-around).
- mem_rd_en and mem_we are never high in the same cycle and never high outside RD/WR.
- Back-to-back operation: start may be asserted in the cycle done is high. It is sampled on the next edge, once state is IDLE, so the minimum issue interval is latency + 1.

Decomposition:
- Package store_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10, SZ_RSVD=2'b11
  - state encoding S_IDLE, S_RD, S_WAIT, S_WR, S_DONE, S_ERR (3 bits)
- Sub-module lane_merge: combinational (old_word, data, size, offset) → new_word.
  - Instantiated once.
  - Unit-testable on its own.

Test Plan:
- Word store: addr=0x00000008, size=10, wdata=0xDEADBEEF → one WR cycle with mem_addr=2, mem_wdata=0xDEADBEEF; done 2 cycles after start; no mem_rd_en.
- Byte store: mem[1]=0x11223344, addr=0x00000006, size=00, wdata=0xFFFFFFAB → RD then WR to mem_addr=1 with mem_wdata=0x11AB3344; done at cycle 4.
- Half store: mem[0]=0xAAAABBBB, addr=0x00000002, size=01, wdata=0x00001234 → mem_wdata=0x1234BBBB.
- Misaligned: half at addr=0x00000003, then word at addr=0x00000002, then size=11 → each gives done=misalign=1 one cycle after start, with mem_we and mem_rd_en never asserted.
- Reset mid-op: byte store, rst_n=0 during WAIT → next cycle state IDLE with all outputs 0; mem[...] unchanged.
- Busy/back-to-back: start held high continuously while issuing word stores → one store per 3 cycles; start pulses during busy produce no extra accesses.
